lift_req_queue: RTL and testbench

- Request queue directly upstream of the lift controller FSM.
- Accepts hall-call requests from the button/panel logic, drops invalid and duplicate calls, and buffers the rest in FIFO order.
- Presents the oldest request to the controller as din/qEmpty.
- Pops one entry per controller "done" episode, using a handshake built from the controller's level-type done signal.

---
 rtl/lift_req_queue.sv | 87 ++++++++
 tb/tb_lift_req_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lift_req_queue.sv
// lift_req_queue: hall-call FIFO feeding the lift controller, with duplicate filtering and a done-episode pop handshake
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   req_valid, req_code request strobe and 3-bit call code
//   req_ready           queue not full
//   fsm_done            controller done level; one pop per high episode
//   q_head, q_empty     oldest entry (000 when empty) and empty flag
//   q_count             stored entries, 0..DEPTH
//   pending             one bit per queued call {4D,3D,2D,3U,2U,1U}
//   ovf, ovf_clr        sticky overflow flag and its clear
module lift_req_queue #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [2:0]    req_code,
  output logic          req_ready,
  input  logic          fsm_done,
  output logic [2:0]    q_head,
  output logic          q_empty,
  output logic [AW:0]   q_count,
  output logic [5:0]    pending,
  output logic          ovf,
  input  logic          ovf_clr
);
  typedef enum logic {ARMED, WAIT_LOW} state_t;
  state_t state, state_nx;
  logic [2:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [5:0] req_oh, pop_oh;
  logic [2:0] pop_code;
  logic full, pop, push, fresh, ovf_set;
  // Invalid codes (000, 101) map to zero, so a zero one-hot doubles as the validity test.
  function automatic logic [5:0] onehot(input logic [2:0] c);
    return c == 3'b001 ? 6'b000001 :
           c == 3'b010 ? 6'b000010 :
           c == 3'b011 ? 6'b000100 :
           c == 3'b110 ? 6'b001000 :
           c == 3'b111 ? 6'b010000 :
           c == 3'b100 ? 6'b100000 : 6'b000000;
  endfunction
  assign full     = count == (AW+1)'(DEPTH);
  assign pop_code = mem[rd_ptr];
  assign req_oh   = onehot(req_code);
  assign pop_oh   = onehot(pop_code);
  assign q_head   = count != '0 ? mem[rd_ptr] : 3'b000;
  assign q_empty  = count == '0;
  assign req_ready = !full;
  assign q_count  = count;
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    if (state == ARMED) begin
      pop = fsm_done && !q_empty;
      state_nx = pop ? WAIT_LOW : ARMED;
    end else begin
      state_nx = fsm_done ? WAIT_LOW : ARMED;
    end
  end
  // A code leaving the queue this cycle may be re-queued in the same cycle.
  assign fresh   = req_valid && req_oh != '0 &&
                   ((pending & req_oh) == '0 || (pop && pop_code == req_code));
  assign push    = fresh && !full;
  assign ovf_set = fresh && full;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= req_code;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ARMED;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr  <= push ? wr_ptr + 1'b1 : wr_ptr;
      count   <= count + (AW+1)'(push) - (AW+1)'(pop);
      pending <= (pending & ~(pop ? pop_oh : 6'b0)) | (push ? req_oh : 6'b0);
      ovf     <= ovf_set || (ovf && !ovf_clr);
    end
  end
endmodule

// File: tb/tb_lift_req_queue.sv
// tb_lift_req_queue: directed bench for lift_req_queue; DEPTH=8 and DEPTH=4 instances share stimulus against a queue model
module tb_lift_req_queue;
  logic clk = 0, rst_n = 0, req_valid = 0, fsm_done = 1, ovf_clr = 0;
  logic [2:0] req_code = 0;
  logic r8, e8, o8, r4, e4, o4;
  logic [2:0] h8, h4;
  logic [3:0] c8;
  logic [2:0] c4;
  logic [5:0] p8, p4;
  int n_cmp = 0, n_bad = 0;
  bit chk_on = 0;

  lift_req_queue u8 (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_code(req_code),
    .req_ready(r8), .fsm_done(fsm_done), .q_head(h8), .q_empty(e8), .q_count(c8),
    .pending(p8), .ovf(o8), .ovf_clr(ovf_clr));
  lift_req_queue #(.DEPTH(4), .AW(2)) u4 (.clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_code(req_code), .req_ready(r4), .fsm_done(fsm_done), .q_head(h4), .q_empty(e4),
    .q_count(c4), .pending(p4), .ovf(o4), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  // Model: each instance is a plain FIFO of codes plus a set of queued calls.
  logic [2:0] mq [2][$];
  int dep [2] = '{8, 4};
  logic [5:0] mpend [2];
  bit movf [2], marmed [2];
  bit m_pop, m_acc, m_full;
  logic [2:0] m_hc;
  int m_b;

  function automatic int cbit(input logic [2:0] c);
    case (c)
      3'b001: return 0;
      3'b010: return 1;
      3'b011: return 2;
      3'b110: return 3;
      3'b111: return 4;
      3'b100: return 5;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        mpend[k] = 0;
        movf[k] = 0;
        marmed[k] = 1;
      end else begin
        m_pop = marmed[k] && fsm_done && mq[k].size() > 0;
        m_hc = m_pop ? mq[k][0] : 3'b000;
        m_b = cbit(req_code);
        m_acc = req_valid && m_b >= 0;
        if (m_acc && mpend[k][m_b] && !(m_pop && m_hc == req_code)) m_acc = 0;
        m_full = mq[k].size() == dep[k];
        if (m_pop) begin
          void'(mq[k].pop_front());
          mpend[k][cbit(m_hc)] = 0;
        end
        if (m_acc && !m_full) begin
          mq[k].push_back(req_code);
          mpend[k][m_b] = 1;
        end
        movf[k] = (m_acc && m_full) ? 1'b1 : ovf_clr ? 1'b0 : movf[k];
        marmed[k] = m_pop ? 1'b0 : !fsm_done ? 1'b1 : marmed[k];
      end
    end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_on)
      for (int k = 0; k < 2; k++) begin
        cmp(k == 0 ? "d8.q_head" : "d4.q_head", k == 0 ? h8 : h4, mq[k].size() > 0 ? mq[k][0] : 0);
        cmp(k == 0 ? "d8.q_empty" : "d4.q_empty", k == 0 ? e8 : e4, mq[k].size() == 0);
        cmp(k == 0 ? "d8.q_count" : "d4.q_count", k == 0 ? c8 : c4, mq[k].size());
        cmp(k == 0 ? "d8.req_ready" : "d4.req_ready", k == 0 ? r8 : r4, mq[k].size() < dep[k]);
        cmp(k == 0 ? "d8.pending" : "d4.pending", k == 0 ? p8 : p4, mpend[k]);
        cmp(k == 0 ? "d8.ovf" : "d4.ovf", k == 0 ? o8 : o4, movf[k]);
      end

  task automatic cyc(input bit v, input logic [2:0] c, input bit d, input bit clr = 0);
    req_valid = v;
    req_code = c;
    fsm_done = d;
    ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(0, 0, 1);
    chk_on = 1;
    cyc(0, 0, 1);
    rst_n = 1;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cmp("reset q_empty", e8, 1);
    cmp("reset q_head", h8, 0);
    cmp("reset q_count", c8, 0);
    cmp("reset req_ready", r8, 1);
    // done held high: one pop per episode
    cyc(1, 3'b010, 1);
    cmp("first push head", h8, 3'b010);
    cyc(1, 3'b111, 1);
    cyc(1, 3'b100, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cmp("one pop head", h8, 3'b111);
    cmp("one pop count", c8, 2);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    cmp("second pop head", h8, 3'b100);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    // duplicate and invalid filtering
    cyc(1, 3'b011, 0);
    cyc(1, 3'b011, 0);
    cyc(1, 3'b000, 0);
    cyc(1, 3'b101, 0);
    cmp("dup count", c8, 1);
    cmp("dup pending", p8, 6'b000100);
    cmp("dup ovf", o8, 0);
    // fill: DEPTH=8 holds all six codes, DEPTH=4 overflows
    cyc(1, 3'b001, 0);
    cyc(1, 3'b011, 0);
    cyc(1, 3'b010, 0);
    cyc(1, 3'b001, 0);
    cyc(1, 3'b110, 0);
    cyc(1, 3'b111, 0);
    cyc(1, 3'b100, 0);
    cmp("fill count8", c8, 6);
    cmp("fill pending8", p8, 6'b111111);
    cmp("full ready4", r4, 0);
    cmp("full ovf4", o4, 1);
    cyc(0, 0, 0, 1);
    cmp("ovf clr4", o4, 0);
    cyc(1, 3'b111, 0, 1);
    cmp("ovf set wins4", o4, 1);
    cyc(0, 0, 0, 1);
    // pop and re-push of the head code; DEPTH=4 is full so rejects it
    cyc(1, 3'b011, 1);
    cmp("repush count8", c8, 6);
    cmp("repush pend8", p8[2], 1);
    cmp("full repush count4", c4, 3);
    cmp("full repush pend4", p4[2], 0);
    cmp("full repush ovf4", o4, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 3'b001, 1);
    cmp("simul count8", c8, 6);
    cmp("simul pend8", p8[0], 1);
    cmp("simul head8", h8, 3'b010);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      if (i == 3) cmp("wrap head8", h8, 3'b011);
    end
    cmp("drain count8", c8, 0);
    // reset mid-operation with the pop FSM waiting for done low
    cyc(1, 3'b001, 0);
    cyc(1, 3'b010, 0);
    cyc(1, 3'b011, 0);
    cyc(1, 3'b110, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cmp("pre-reset count8", c8, 3);
    rst_n = 0;
    cyc(0, 0, 1);
    rst_n = 1;
    cmp("mid reset empty", e8, 1);
    cmp("mid reset head", h8, 0);
    cmp("mid reset pending", p8, 0);
    cmp("mid reset count4", c4, 0);
    cyc(1, 3'b100, 1);
    cmp("post reset push", c8, 1);
    cyc(0, 0, 1);
    cmp("post reset armed pop", c8, 0);
    cyc(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
